// File: rtl/tri_band_pkg.sv
// Shared types and region helpers for the tri_band_extract matrix-region streamer.
// Mode values above MODE_DIAG all decode to a full passthrough.
package tri_band_pkg;

  typedef enum logic [2:0] {
    MODE_UPPER  = 3'd0,
    MODE_LOWER  = 3'd1,
    MODE_SUPPER = 3'd2,
    MODE_SLOWER = 3'd3,
    MODE_DIAG   = 3'd4,
    MODE_FULL   = 3'd5
  } mode_e;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] c;
  } pos_t;

  function automatic mode_e decode_mode(logic [2:0] m);
    return (m > 3'd4) ? MODE_FULL : mode_e'(m);
  endfunction

  function automatic logic keep(mode_e m, logic [31:0] r, logic [31:0] c);
    case (m)
      MODE_UPPER:  return c >= r;
      MODE_LOWER:  return c <= r;
      MODE_SUPPER: return c > r;
      MODE_SLOWER: return c < r;
      MODE_DIAG:   return c == r;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic int unsigned min2(int unsigned a, int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Raster position of the final kept element; tags tlast when masked beats are dropped.
  function automatic pos_t last_kept_pos(mode_e m, int unsigned rows, int unsigned cols);
    pos_t p;
    p.r = rows - 1;
    p.c = cols - 1;
    case (m)
      MODE_UPPER:  p.r = min2(rows, cols) - 1;
      MODE_SUPPER: p.r = min2(rows, cols - 1) - 1;
      MODE_LOWER:  p.c = min2(rows, cols) - 1;
      MODE_SLOWER: p.c = min2(rows - 1, cols) - 1;
      MODE_DIAG: begin
        p.r = min2(rows, cols) - 1;
        p.c = min2(rows, cols) - 1;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tri_band_extract_axis_out_reg.sv
// One-entry AXI-Stream output register; a pop and a reload in the same cycle
// produce back-to-back beats with no bubble.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  last_reg;

  assign in_ready   = !valid_reg || out_tready;
  assign out_tvalid = valid_reg;
  assign out_tdata  = data_reg;
  assign out_tlast  = last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
    end else if (out_tready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/tri_band_extract.sv
// Streaming region extractor: forwards (or zero-fills) the elements of a raster-order
// ROWS x COLS matrix that fall in the selected triangle/diagonal, with framing checks.
module tri_band_extract
  import tri_band_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  input  logic                  zero_fill,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic                  err_frame,
  output logic                  matrix_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  logic [RW-1:0]         r_reg, r_next;
  logic [CW-1:0]         c_reg, c_next;
  mode_e                 mode_reg;
  logic                  zf_reg;
  logic                  err_frame_reg, matrix_done_reg;

  mode_e                 eff_mode;
  logic                  eff_zf;
  logic                  at_origin, at_final, accept, kept;
  logic                  beat, beat_last, reg_in_ready;
  logic [DATA_WIDTH-1:0] beat_data;
  pos_t                  lk;

  assign in_tready   = !rst && reg_in_ready;
  assign accept      = in_tvalid && in_tready;
  assign err_frame   = err_frame_reg;
  assign matrix_done = matrix_done_reg;

  always_comb begin
    at_origin = (r_reg == '0) && (c_reg == '0);
    at_final  = (r_reg == R_LAST) && (c_reg == C_LAST);
    // The (0,0) element already obeys the mode presented with it.
    eff_mode  = at_origin ? decode_mode(mode) : mode_reg;
    eff_zf    = at_origin ? zero_fill : zf_reg;
    kept      = keep(eff_mode, 32'(r_reg), 32'(c_reg));
    lk        = last_kept_pos(eff_mode, ROWS, COLS);
    beat      = accept && (kept || eff_zf);
    beat_data = kept ? in_tdata : '0;
    beat_last = eff_zf ? at_final : ((32'(r_reg) == lk.r) && (32'(c_reg) == lk.c));
  end

  always_comb begin
    r_next = r_reg;
    c_next = c_reg;
    if (in_tlast) begin
      // Early tlast resyncs so the next element starts a fresh matrix.
      r_next = '0;
      c_next = '0;
    end else if (c_reg == C_LAST) begin
      c_next = '0;
      r_next = (r_reg == R_LAST) ? '0 : r_reg + 1'b1;
    end else begin
      c_next = c_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg           <= '0;
      c_reg           <= '0;
      mode_reg        <= MODE_UPPER;
      zf_reg          <= 1'b0;
      err_frame_reg   <= 1'b0;
      matrix_done_reg <= 1'b0;
    end else begin
      err_frame_reg   <= accept && (in_tlast != at_final);
      matrix_done_reg <= accept && (in_tlast || at_final);
      if (accept) begin
        r_reg <= r_next;
        c_reg <= c_next;
        if (at_origin) begin
          mode_reg <= eff_mode;
          zf_reg   <= eff_zf;
        end
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (beat),
    .load_data (beat_data),
    .load_last (beat_last),
    .in_ready  (reg_in_ready),
    .out_tdata (out_tdata),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast (out_tlast)
  );

endmodule

// File: tb/tb_tri_band_extract.sv
// Directed bench for tri_band_extract: a 4x4 instance driven from a vector table plus
// framing/reset sequences, and a 3x5 instance under random output backpressure.
module tb_tri_band_extract;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic        zero_fill;
  logic [31:0] in_tdata;
  logic        in_tvalid, in_tlast;
  logic        sel;

  logic        in_tready4, out_tvalid4, out_tready4, out_tlast4, err_frame4, matrix_done4;
  logic [31:0] out_tdata4;
  logic        in_tready3, out_tvalid3, out_tready3, out_tlast3, err_frame3, matrix_done3;
  logic [31:0] out_tdata3;

  int n_vec = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  bit rand_en = 1'b0;

  logic [31:0] q4d[$], q3d[$], exp_d[$];
  bit          q4l[$], q3l[$], exp_l[$];

  always #5 clk = ~clk;

  tri_band_extract #(.ROWS(4), .COLS(4), .DATA_WIDTH(32)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .zero_fill(zero_fill),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid && !sel), .in_tready(in_tready4),
    .in_tlast(in_tlast), .out_tdata(out_tdata4), .out_tvalid(out_tvalid4),
    .out_tready(out_tready4), .out_tlast(out_tlast4), .err_frame(err_frame4),
    .matrix_done(matrix_done4)
  );

  tri_band_extract #(.ROWS(3), .COLS(5), .DATA_WIDTH(32)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode), .zero_fill(zero_fill),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid && sel), .in_tready(in_tready3),
    .in_tlast(in_tlast), .out_tdata(out_tdata3), .out_tvalid(out_tvalid3),
    .out_tready(out_tready3), .out_tlast(out_tlast3), .err_frame(err_frame3),
    .matrix_done(matrix_done3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // 4x4 monitor: beats and pulse counts, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_tvalid4 && out_tready4) begin
        q4d.push_back(out_tdata4);
        q4l.push_back(out_tlast4);
      end
      if (err_frame4) err_cnt++;
      if (matrix_done4) done_cnt++;
    end
  end

  // 3x5 monitor: a stalled beat must stay put until taken.
  logic        p_stall = 1'b0;
  logic [31:0] p_d;
  logic        p_l;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_stall) begin
        chk("hold_valid", 32'(out_tvalid3), 32'd1);
        chk("hold_data", out_tdata3, p_d);
        chk("hold_last", 32'(out_tlast3), 32'(p_l));
      end
      if (out_tvalid3 && out_tready3) begin
        q3d.push_back(out_tdata3);
        q3l.push_back(out_tlast3);
      end
    end
    p_stall = !rst && out_tvalid3 && !out_tready3;
    p_d = out_tdata3;
    p_l = out_tlast3;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) out_tready3 = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] m, input logic zf);
    int guard;
    guard = 0;
    in_tdata = d; in_tlast = last; mode = m; zero_fill = zf; in_tvalid = 1'b1;
    @(negedge clk);
    while (!(sel ? in_tready3 : in_tready4)) begin
      guard++;
      if (guard > 200) begin
        n_vec++; n_fail++;
        $display("FAIL accept_timeout: got no in_tready, expected accept of %0d", d);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_exp(input logic [31:0] base, input logic [15:0] mask, input logic zf);
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin exp_d.push_back(base + 32'(i)); exp_l.push_back(1'b0); end
      else if (zf) begin exp_d.push_back(32'd0); exp_l.push_back(1'b0); end
    end
    exp_l[exp_l.size() - 1] = 1'b1;
  endtask

  task automatic compare(input string tag, input logic [31:0] gd[$], input bit gl[$]);
    chk({tag, "_count"}, 32'(gd.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < gd.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), gd[i], exp_d[i]);
      chk($sformatf("%s_last%0d", tag, i), 32'(gl[i]), 32'(exp_l[i]));
    end
    exp_d.delete();
    exp_l.delete();
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [2:0]  junk;   // mode driven on elements 1..15, must be ignored
    logic        zf;
    logic [15:0] mask;   // bit i = raster element i kept
    logic [31:0] base;
  } vec_t;

  vec_t   vecs[7];
  longint t0, t1;

  initial begin
    vecs[0] = '{3'd0, 3'd4, 1'b0, 16'b1000_1100_1110_1111, 32'd1};
    vecs[1] = '{3'd1, 3'd4, 1'b0, 16'b1111_0111_0011_0001, 32'd1};
    vecs[2] = '{3'd4, 3'd1, 1'b0, 16'b1000_0100_0010_0001, 32'd1};
    vecs[3] = '{3'd2, 3'd0, 1'b1, 16'b0000_1000_1100_1110, 32'd1};
    vecs[4] = '{3'd3, 3'd2, 1'b0, 16'b0111_0011_0001_0000, 32'd101};
    vecs[5] = '{3'd6, 3'd0, 1'b0, 16'b1111_1111_1111_1111, 32'd201};
    vecs[6] = '{3'd4, 3'd5, 1'b1, 16'b1000_0100_0010_0001, 32'd301};

    rst = 1'b1; sel = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0;
    mode = '0; zero_fill = 1'b0; out_tready4 = 1'b1; out_tready3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_tready4", 32'(in_tready4), 32'd0);
    chk("rst_in_tready3", 32'(in_tready3), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_tvalid", 32'(out_tvalid4), 32'd0);
    chk("rst_out_tdata", out_tdata4, 32'd0);
    chk("rst_out_tlast", 32'(out_tlast4), 32'd0);
    chk("rst_err_frame", 32'(err_frame4), 32'd0);
    chk("rst_matrix_done", 32'(matrix_done4), 32'd0);

    // Table: back-to-back matrices, mode/zero_fill scrambled after (0,0).
    t0 = $time;
    foreach (vecs[v]) begin
      add_exp(vecs[v].base, vecs[v].mask, vecs[v].zf);
      for (int i = 0; i < 16; i++)
        send(vecs[v].base + 32'(i), i == 15, (i == 0) ? vecs[v].mode : vecs[v].junk,
             (i == 0) ? vecs[v].zf : !vecs[v].zf);
    end
    t1 = $time;
    idle(4);
    chk("throughput_cycles", 32'((t1 - t0) / 10), 32'(16 * 7));
    compare("table", q4d, q4l);
    q4d.delete(); q4l.delete();
    chk("table_done_cnt", 32'(done_cnt), 32'd7);
    chk("table_err_cnt", 32'(err_cnt), 32'd0);

    // Early in_tlast on element 7, then a mode-0 matrix from the resynced origin.
    err_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      send(32'(i + 1), i == 6, 3'd5, 1'b0);
      exp_d.push_back(32'(i + 1)); exp_l.push_back(1'b0);
    end
    chk("early_err_pulse", 32'(err_frame4), 32'd1);
    chk("early_done_pulse", 32'(matrix_done4), 32'd1);
    add_exp(32'd1, 16'b1000_1100_1110_1111, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(32'(i + 1), i == 15, 3'd0, 1'b0);
      if (i == 0) begin
        chk("early_err_one_cycle", 32'(err_frame4), 32'd0);
        chk("early_done_one_cycle", 32'(matrix_done4), 32'd0);
      end
    end
    idle(4);
    compare("early", q4d, q4l);
    q4d.delete(); q4l.delete();
    chk("early_err_cnt", 32'(err_cnt), 32'd1);
    chk("early_done_cnt", 32'(done_cnt), 32'd2);

    // Reset after element 9 of a matrix.
    for (int i = 0; i < 9; i++) send(32'(i + 1), 1'b0, 3'd0, 1'b1);
    chk("prereset_valid", 32'(out_tvalid4), 32'd1);
    in_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("postreset_valid", 32'(out_tvalid4), 32'd0);
    chk("postreset_data", out_tdata4, 32'd0);
    q4d.delete(); q4l.delete();
    err_cnt = 0; done_cnt = 0;
    add_exp(32'd1, 16'b1000_1100_1110_1111, 1'b0);
    for (int i = 0; i < 16; i++) send(32'(i + 1), i == 15, 3'd0, 1'b0);
    idle(4);
    compare("reset", q4d, q4l);
    chk("reset_done_cnt", 32'(done_cnt), 32'd1);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);

    // 3x5 strict lower under random backpressure.
    sel = 1'b1;
    rand_en = 1'b1;
    for (int i = 0; i < 15; i++) send(32'(i + 1), i == 14, 3'd3, 1'b0);
    idle(1);
    for (int k = 0; k < 60 && q3d.size() < 3; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    rand_en = 1'b0;
    exp_d.push_back(32'd6);  exp_l.push_back(1'b0);
    exp_d.push_back(32'd11); exp_l.push_back(1'b0);
    exp_d.push_back(32'd12); exp_l.push_back(1'b1);
    compare("r3c5", q3d, q3l);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_band_extract.md
# tri_band_extract

Streaming matrix-region extractor: accepts a ROWS×COLS matrix in row-major raster order on an AXI-Stream-style input and forwards only the elements inside a selected region (upper, lower, strict, diagonal or full). Masked elements are either dropped or replaced by zero. It adds correct backpressure, per-matrix mode latching, an output `tlast` and input-framing error detection. It sits between the matrix source DMA/FIFO and the downstream arithmetic blocks of the matrix-manipulation IP.

## Interface
Parameters
- ROWS, 4, matrix rows, ≥2
- COLS, 4, matrix columns, ≥2
- DATA_WIDTH, 32, element width in bits

Ports
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mode  in  3  region select: 0 upper (c≥r), 1 lower (c≤r), 2 strict upper (c>r), 3 strict lower (c<r), 4 diagonal (c=r), 5–7 full passthrough
- zero_fill  in  1  1: masked elements emitted as 0; 0: masked elements dropped
- in_tdata  in  DATA_WIDTH  element
- in_tvalid  in  1  element valid
- in_tready  out  1  block accepts element
- in_tlast  in  1  source marks element (ROWS-1, COLS-1)
- out_tdata  out  DATA_WIDTH  kept element, or 0 when zero-filled
- out_tvalid  out  1  output valid
- out_tready  in  1  sink accepts
- out_tlast  out  1  last output beat of the current matrix
- err_frame  out  1  one-cycle pulse on in_tlast framing mismatch
- matrix_done  out  1  one-cycle pulse when the last input element of a matrix is accepted

## Operation
- Input handshake occurs when in_tvalid && in_tready. Each accepted element advances the column counter c (0..COLS-1). At COLS-1, c wraps to 0 and the row counter r increments. At (ROWS-1, COLS-1), both wrap to 0.
- mode and zero_fill are latched on the element accepted at (0,0) and held until that matrix ends. Changes mid-matrix have no effect until the next (0,0).
- Keep test uses the latched mode on (r,c). Kept elements load the output register with in_tdata.
- Masked elements:
  - zero_fill=1: load the output register with 0.
  - zero_fill=0: consumed, with no output beat.
- out_tlast:
  - zero_fill=1 or passthrough: set on the output beat for (ROWS-1, COLS-1).
  - Drop mode: set on the beat of the last kept element in raster order:
    - upper: (min(ROWS,COLS)-1, COLS-1)
    - strict upper: (min(ROWS,COLS-1)-1, COLS-1)
    - lower: (ROWS-1, min(ROWS,COLS)-1)
    - strict lower: (ROWS-1, min(ROWS-1,COLS)-1)
    - diagonal: (min(ROWS,COLS)-1, min(ROWS,COLS)-1)
- Framing check: an accepted element where in_tlast ≠ (r==ROWS-1 && c==COLS-1) pulses err_frame.
  - If in_tlast=1 early, the element is processed normally, then counters resync to (0,0), and matrix_done pulses.
  - If in_tlast=0 at the final position, counters wrap normally.
- No arithmetic on data; counters are $clog2(ROWS) and $clog2(COLS) bits wide, or 1 bit where the dimension is ≤1.

## Timing
- Reset values: out_tvalid=0, out_tdata=0, out_tlast=0, err_frame=0, matrix_done=0, r=c=0, latched mode=0, latched zero_fill=0. in_tready=0 while rst=1.
- Single output register stage. in_tready = !out_tvalid || out_tready (combinational).
- Full throughput is one element per cycle under continuous out_tready.
- Latency: a kept element accepted in cycle N is on out_tdata/out_tvalid in cycle N+1.
- out_tvalid=1 holds out_tdata and out_tlast stable until out_tready.
- Simultaneous output pop and input accept in the same cycle reloads the register with no bubble.
- A dropped element accepted while the register pops clears out_tvalid next cycle.
- err_frame and matrix_done are registered and high for exactly one cycle, the cycle after the triggering accept.
- Reset mid-matrix discards the output register contents and restarts at (0,0) on the first accept after rst falls.

## Structure
- Package `tri_band_pkg`:
  - mode_e enum (MODE_UPPER…MODE_FULL)
  - function `keep(mode, r, c)`
  - function `last_kept_pos(mode, ROWS, COLS)` returning (r,c) per Operation
- Sub-module `axis_out_reg`: one-entry output register with valid/ready, tdata and tlast. Parameterised on DATA_WIDTH.
- Top holds the counters, mode latch, framing check and pulse outputs.

## Test plan
- 4×4, mode 0, zero_fill 0, inputs 1..16, out_tready=1 → outputs 1,2,3,4,6,7,8,11,12,16, out_tlast on 16, matrix_done once, throughput 1/cycle after first beat.
- 4×4, mode 1 then mode 4 back-to-back, drop mode → 1,5,6,9,10,11,13,14,15,16 (tlast on 16), then 1,6,11,16 (tlast on 16). Mode changed at element 5 of the second matrix is ignored.
- 4×4, mode 2, zero_fill 1, inputs 1..16 → 16 beats: 0,2,3,4,0,0,7,8,0,0,0,12,0,0,0,0, tlast on 16th beat.
- ROWS=3, COLS=5, mode 3, out_tready randomly toggled 50% → outputs 6,11,12, tlast on 12, no loss or duplication, out_tdata stable while stalled.
- 4×4, in_tlast asserted on element 7 → err_frame pulse, counters resync, next element treated as (0,0) of a new matrix.
- rst asserted for 1 cycle after element 9 of a 4×4 mode 0 matrix → out_tvalid=0 next cycle. Inputs 1..16 then produce the full mode-0 sequence from (0,0).
